// File: rtl/mc_ctrl_ws.sv
// Multi-cycle MIPS main control FSM with variable-latency memory handshake,
// bus-error timeout, EXL interrupt masking and exception sequencing.
module mc_ctrl_ws #(
  parameter int TIMEOUT = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] iclass,
  input  logic       br_taken,
  input  logic       intreq,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       mem_we,
  output logic       irwr,
  output logic       pcwr,
  output logic       regwrite,
  output logic       exlset,
  output logic       exlclr,
  output logic       intpc,
  output logic [1:0] exc_code,
  output logic       exl,
  output logic       busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CNT_MAX_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX = CNT_MAX_I[CW-1:0];

  localparam logic [2:0] C_ALU     = 3'd0;
  localparam logic [2:0] C_LOAD    = 3'd1;
  localparam logic [2:0] C_STORE   = 3'd2;
  localparam logic [2:0] C_BRANCH  = 3'd3;
  localparam logic [2:0] C_JUMP    = 3'd4;
  localparam logic [2:0] C_JAL     = 3'd5;
  localparam logic [2:0] C_ERET    = 3'd6;
  localparam logic [2:0] C_ILLEGAL = 3'd7;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_INT  = 2'd1;
  localparam logic [1:0] CAUSE_ILL  = 2'd2;
  localparam logic [1:0] CAUSE_BUS  = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEMADDR, S_MEMACC, S_WB, S_BRANCH, S_JUMP, S_EXC
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cls_q, cls_d;
  logic        exl_q, exl_d;
  logic [1:0]  exc_code_q, exc_code_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic mem_req_c, mem_we_c, irwr_c, pcwr_c, regwrite_c;
  logic exlset_c, exlclr_c, intpc_c;
  logic [1:0] cause;
  logic done;
  logic timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_MAX) && !mem_rdy;

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    exl_d      = exl_q;
    exc_code_d = exc_code_q;
    cnt_d      = '0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    irwr_c     = 1'b0;
    pcwr_c     = 1'b0;
    regwrite_c = 1'b0;
    exlset_c   = 1'b0;
    exlclr_c   = 1'b0;
    intpc_c    = 1'b0;
    cause      = CAUSE_NONE;
    done       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_rdy) begin
          irwr_c  = 1'b1;
          pcwr_c  = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_EXC;
          cause   = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        cls_d = iclass;
        case (iclass)
          C_ALU:             state_d = S_EXEC;
          C_LOAD, C_STORE:   state_d = S_MEMADDR;
          C_BRANCH:          state_d = S_BRANCH;
          C_JUMP, C_JAL, C_ERET: state_d = S_JUMP;
          default: begin
            state_d = S_EXC;
            cause   = CAUSE_ILL;
          end
        endcase
      end
      S_EXEC:    state_d = S_WB;
      S_MEMADDR: state_d = S_MEMACC;
      S_MEMACC: begin
        mem_req_c = 1'b1;
        mem_we_c  = (cls_q == C_STORE);
        if (mem_rdy) begin
          if (cls_q == C_LOAD) state_d = S_WB;
          else                 done    = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_EXC;
          cause   = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        regwrite_c = 1'b1;
        done       = 1'b1;
      end
      S_BRANCH: begin
        pcwr_c = br_taken;
        done   = 1'b1;
      end
      S_JUMP: begin
        pcwr_c     = 1'b1;
        regwrite_c = (cls_q == C_JAL);
        if (cls_q == C_ERET) begin
          exlclr_c = 1'b1;
          exl_d    = 1'b0;
        end
        done = 1'b1;
      end
      S_EXC: begin
        pcwr_c   = 1'b1;
        intpc_c  = 1'b1;
        exlset_c = 1'b1;
        exl_d    = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Interrupts are masked by the pre-edge EXL, so a completing ERET still returns to FETCH.
    if (done) begin
      if (intreq && !exl_q) begin
        state_d = S_EXC;
        cause   = CAUSE_INT;
      end else begin
        state_d = S_FETCH;
      end
    end

    if (state_d == S_EXC) exc_code_d = cause;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      cls_q      <= C_ALU;
      exl_q      <= 1'b0;
      exc_code_q <= CAUSE_NONE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      exl_q      <= exl_d;
      exc_code_q <= exc_code_d;
      cnt_q      <= cnt_d;
    end
  end

  // Strobes are forced low while reset is asserted so an abandoned access fires nothing.
  assign mem_req  = rst_n & mem_req_c;
  assign mem_we   = rst_n & mem_we_c;
  assign irwr     = rst_n & irwr_c;
  assign pcwr     = rst_n & pcwr_c;
  assign regwrite = rst_n & regwrite_c;
  assign exlset   = rst_n & exlset_c;
  assign exlclr   = rst_n & exlclr_c;
  assign intpc    = rst_n & intpc_c;
  assign busy     = rst_n & (state_q != S_FETCH);
  assign exl      = exl_q;
  assign exc_code = exc_code_q;

endmodule

// File: tb/tb_mc_ctrl_ws.sv
// Randomised bench for mc_ctrl_ws: builds an expected per-cycle trace for each
// instruction from its class, memory latencies and interrupt level.
module tb_mc_ctrl_ws;

  localparam int T = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] iclass = 3'd0;
  logic       br_taken = 1'b0;
  logic       intreq = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       mem_req, mem_we, irwr, pcwr, regwrite, exlset, exlclr, intpc, exl, busy;
  logic [1:0] exc_code;

  mc_ctrl_ws #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .iclass(iclass), .br_taken(br_taken),
    .intreq(intreq), .mem_rdy(mem_rdy), .mem_req(mem_req), .mem_we(mem_we),
    .irwr(irwr), .pcwr(pcwr), .regwrite(regwrite), .exlset(exlset),
    .exlclr(exlclr), .intpc(intpc), .exc_code(exc_code), .exl(exl), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        irq;
    logic        br;
    logic [2:0]  ic;
    logic [11:0] exp;
  } cyc_t;

  cyc_t q[$];
  int   tagq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic       exl_m = 1'b0;
  logic [1:0] code_m = 2'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic string tname(input int t);
    case (t)
      0: return "ALU";
      1: return "LOAD";
      2: return "STORE";
      3: return "BRANCH";
      4: return "JUMP";
      5: return "JAL";
      6: return "ERET";
      7: return "ILLEGAL";
      default: return "RESET";
    endcase
  endfunction

  function automatic logic [11:0] observed();
    return {exc_code, exl, busy, mem_req, mem_we, irwr, pcwr, regwrite, exlset, exlclr, intpc};
  endfunction

  function automatic logic [11:0] mk(input logic req, we, ir, pc, rw, xs, xc, ip, bz);
    return {code_m, exl_m, bz, req, we, ir, pc, rw, xs, xc, ip};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] ric();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic push(input logic rdy, irq, br, input logic [2:0] ic,
                      input logic [11:0] e, input int tag);
    cyc_t c;
    c.rdy = rdy; c.irq = irq; c.br = br; c.ic = ic; c.exp = e;
    q.push_back(c);
    tagq.push_back(tag);
  endtask

  task automatic exc_cycle(input logic [1:0] cause, input int tag);
    code_m = cause;
    push(rb(), rb(), rb(), ric(), mk(0, 0, 0, 1, 0, 1, 0, 1, 1), tag);
    exl_m = 1'b1;
  endtask

  // Wait cycles of a memory access; on timeout the bus-error exception is appended.
  task automatic mem_wait(input int w, input logic fetch, input logic we,
                          input int tag, output logic ok);
    logic to;
    int   n;
    to = (T != 0) && (w >= T);
    n  = to ? T : w;
    for (int i = 0; i < n; i++)
      push(1'b0, rb(), rb(), ric(), mk(1, we, 0, 0, 0, 0, 0, 0, !fetch), tag);
    ok = !to;
    if (to) exc_cycle(2'd3, tag);
  endtask

  task automatic cmpl_cycle(input logic rdy, input logic br, input logic [11:0] e,
                            input logic irq, input int tag, input logic eret);
    logic pre;
    pre = exl_m;
    push(rdy, irq, br, ric(), e, tag);
    if (eret) exl_m = 1'b0;
    if (irq && !pre) exc_cycle(2'd1, tag);
  endtask

  task automatic gen(input int cls, input int wf, input int wm, input logic br, input logic irq);
    logic ok;
    mem_wait(wf, 1'b1, 1'b0, cls, ok);
    if (!ok) return;
    push(1'b1, rb(), rb(), ric(), mk(1, 0, 1, 1, 0, 0, 0, 0, 0), cls);
    push(rb(), rb(), rb(), 3'(cls), mk(0, 0, 0, 0, 0, 0, 0, 0, 1), cls);
    case (cls)
      0: begin
        push(rb(), rb(), rb(), ric(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1), cls);
        cmpl_cycle(rb(), rb(), mk(0, 0, 0, 0, 1, 0, 0, 0, 1), irq, cls, 1'b0);
      end
      1, 2: begin
        push(rb(), rb(), rb(), ric(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1), cls);
        mem_wait(wm, 1'b0, cls == 2, cls, ok);
        if (!ok) return;
        if (cls == 1) begin
          push(1'b1, rb(), rb(), ric(), mk(1, 0, 0, 0, 0, 0, 0, 0, 1), cls);
          cmpl_cycle(rb(), rb(), mk(0, 0, 0, 0, 1, 0, 0, 0, 1), irq, cls, 1'b0);
        end else begin
          cmpl_cycle(1'b1, rb(), mk(1, 1, 0, 0, 0, 0, 0, 0, 1), irq, cls, 1'b0);
        end
      end
      3: cmpl_cycle(rb(), br, mk(0, 0, 0, br, 0, 0, 0, 0, 1), irq, cls, 1'b0);
      4, 5, 6: cmpl_cycle(rb(), rb(), mk(0, 0, 0, 1, cls == 5, 0, cls == 6, 0, 1),
                          irq, cls, cls == 6);
      default: exc_cycle(2'd2, cls);
    endcase
  endtask

  // Starts on a falling edge; drives each cycle's inputs and samples 1 unit later.
  task automatic run_q();
    cyc_t c;
    int   t;
    while (q.size() > 0) begin
      c = q.pop_front();
      t = tagq.pop_front();
      mem_rdy = c.rdy; intreq = c.irq; br_taken = c.br; iclass = c.ic;
      #1;
      check_val($sformatf("%s@%0d", tname(t), cyc), {20'd0, observed()}, {20'd0, c.exp});
      cyc++;
      @(negedge clk);
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 2);
    if (r < 8) return T - 1;
    if (r == 8) return T + $urandom_range(0, 2);
    return $urandom_range(0, 6);
  endfunction

  initial begin
    mem_rdy = 1'b1;
    #12;
    check_val("reset_hold", {20'd0, observed()}, 32'd0);
    @(negedge clk);
    check_val("reset_hold2", {20'd0, observed()}, 32'd0);

    gen(0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_q();

    gen(1, 0, 3, 1'b0, 1'b0);           run_q();
    gen(2, 0, T, 1'b0, 1'b0);           run_q();
    gen(2, 0, T - 1, 1'b0, 1'b0);       run_q();
    gen(0, T, 0, 1'b0, 1'b0);           run_q();
    gen(0, 1, 0, 1'b0, 1'b1);           run_q();
    gen(0, 0, 0, 1'b0, 1'b1);           run_q();
    gen(6, 0, 0, 1'b0, 1'b1);           run_q();
    gen(0, 0, 0, 1'b0, 1'b1);           run_q();
    gen(7, 0, 0, 1'b0, 1'b0);           run_q();
    gen(3, 0, 0, 1'b0, 1'b0);           run_q();
    gen(3, 0, 0, 1'b1, 1'b0);           run_q();
    gen(5, 2, 0, 1'b0, 1'b0);           run_q();

    // Abandon a fetch by asynchronous reset mid-cycle.
    mem_rdy = 1'b0; intreq = 1'b0;
    #1;
    check_val("pre_reset", {20'd0, observed()}, {20'd0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0)});
    #1 rst_n = 1'b0;
    #1;
    check_val("async_reset", {20'd0, observed()}, 32'd0);
    exl_m = 1'b0; code_m = 2'd0;
    mem_rdy = 1'b1;
    @(negedge clk);
    check_val("reset_rdy", {20'd0, observed()}, 32'd0);
    gen(0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_q();

    for (int k = 0; k < 150; k++) begin
      gen($urandom_range(0, 7), pick_wait(), pick_wait(), rb(), ($urandom_range(0, 3) == 0));
      run_q();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
